// File: rtl/rf_operand_fetch.sv
// rtl/rf_operand_fetch.sv - 2R1W register-file operand fetch with post-reset clear and write-back forwarding
// Owns the RF write port: zero-fills every entry after reset, then serves write-backs and operand reads.
module rf_operand_fetch #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_src1,
  input  logic [ADDR_WIDTH-1:0] in_src2,
  input  logic [ADDR_WIDTH-1:0] in_dst,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_op1,
  output logic [DATA_WIDTH-1:0] out_op2,
  output logic [ADDR_WIDTH-1:0] out_dst,
  output logic [TAG_WIDTH-1:0]  out_tag,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr1,
  input  logic [DATA_WIDTH-1:0] rf_rd_data1,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr2,
  input  logic [DATA_WIDTH-1:0] rf_rd_data2,
  output logic                  rf_wr_en,
  output logic [ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  init_done
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic                    r_out_valid;
  logic [ADDR_WIDTH-1:0]   r_src1;
  logic [ADDR_WIDTH-1:0]   r_src2;
  logic [ADDR_WIDTH-1:0]   r_dst;
  logic [TAG_WIDTH-1:0]    r_tag;
  logic                    r_fwd1;
  logic                    r_fwd2;
  logic [DATA_WIDTH-1:0]   r_fwd_data;

  logic w_run;
  logic w_accept;
  logic w_wb_drop;

  assign w_run     = (r_state == ST_RUN);
  assign in_ready  = w_run & (~r_out_valid | out_ready);
  assign w_accept  = in_valid & in_ready;
  assign w_wb_drop = ZERO_REG && (wb_addr == '0);

  assign wb_ready  = w_run;
  assign init_done = w_run;

  // Read ports follow the incoming op on accept, otherwise keep re-reading the held op.
  assign rf_rd_addr1 = w_accept ? in_src1 : r_src1;
  assign rf_rd_addr2 = w_accept ? in_src2 : r_src2;

  assign rf_wr_en   = w_run ? (wb_valid & ~w_wb_drop) : 1'b1;
  assign rf_wr_addr = w_run ? wb_addr : r_cnt;
  assign rf_wr_data = w_run ? wb_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ADDR) r_state <= ST_RUN;
        end
        ST_RUN:  r_state <= ST_RUN;
        default: r_state <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_src1      <= '0;
      r_src2      <= '0;
      r_dst       <= '0;
      r_tag       <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_src1      <= in_src1;
      r_src2      <= in_src2;
      r_dst       <= in_dst;
      r_tag       <= in_tag;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // The RF returns the pre-write value on a same-edge read/write, so capture the write for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd1     <= 1'b0;
      r_fwd2     <= 1'b0;
      r_fwd_data <= '0;
    end else begin
      r_fwd1     <= rf_wr_en & (rf_wr_addr == rf_rd_addr1);
      r_fwd2     <= rf_wr_en & (rf_wr_addr == rf_rd_addr2);
      r_fwd_data <= rf_wr_data;
    end
  end

  assign out_valid = r_out_valid;
  assign out_dst   = r_dst;
  assign out_tag   = r_tag;
  assign out_op1   = (ZERO_REG && (r_src1 == '0)) ? '0 : (r_fwd1 ? r_fwd_data : rf_rd_data1);
  assign out_op2   = (ZERO_REG && (r_src2 == '0)) ? '0 : (r_fwd2 ? r_fwd_data : rf_rd_data2);

endmodule
